// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers operands, per-group (P,G) and the group carry-ins from a
// group-level lookahead chain. Stage 2 ripples carries inside each group,
// forms the sum and the word flags.
// Optional build macro: CLA_SAT_EN (saturate S on signed overflow).

// Per-group propagate/generate reduction.
module cla_grp_pg #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_p,
  input  logic [GROUP-1:0] i_g,
  output logic             o_p,
  output logic             o_g
);
  // Group P is the AND of bit propagates; group G folds generates LSB to MSB.
  always_comb begin
    o_p = &i_p;
    o_g = 1'b0;
    for (int i = 0; i < GROUP; i++) o_g = i_g[i] | (i_p[i] & o_g);
  end
endmodule

// Intra-group carries and sum, seeded with the group carry-in.
module cla_grp_sum #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_c,
  output logic [GROUP-1:0] o_s
);
  logic [GROUP-1:0] w_p, w_g, w_c;

  // Bit carries inside the group; the group carry-out comes from stage 1.
  always_comb begin
    w_p    = i_a ^ i_b;
    w_g    = i_a & i_b;
    w_c    = '0;
    w_c[0] = i_c;
    for (int i = 1; i < GROUP; i++) w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    o_s    = w_p ^ w_c;
  end
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Pout,
  output logic             Gout,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  // ---------------- operand prep + stage 1 lookahead ----------------
  logic [NG-1:0][GROUP-1:0] w_a, w_beff, w_p, w_g;
  logic [NG-1:0]            w_gp, w_gg;
  logic [NG:0]              w_c;
  logic                     w_c0;

  assign w_a    = A;
  assign w_beff = Sub ? ~B : B;
  assign w_c0   = Cin ^ Sub;
  assign w_p    = w_a ^ w_beff;
  assign w_g    = w_a & w_beff;

  for (genvar k = 0; k < NG; k++) begin : g_pg
    cla_grp_pg #(.GROUP(GROUP)) u_pg (
      .i_p (w_p[k]),
      .i_g (w_g[k]),
      .o_p (w_gp[k]),
      .o_g (w_gg[k])
    );
  end

  // Group-level lookahead: carry into each group from the group (P,G) pairs.
  always_comb begin
    w_c    = '0;
    w_c[0] = w_c0;
    for (int k = 0; k < NG; k++) w_c[k+1] = w_gg[k] | (w_gp[k] & w_c[k]);
  end

  // ---------------- handshake ----------------
  logic [2:1] r_vld_pipe;
  logic       w_adv1, w_adv2;

  assign w_adv2    = !r_vld_pipe[2] | out_ready;
  assign w_adv1    = !r_vld_pipe[1] | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_vld_pipe[2];

  // Valid shift register; a stalled stage 2 also holds stage 1.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_adv1) r_vld_pipe[1] <= in_valid;
      if (w_adv2) r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  // ---------------- stage 1 registers ----------------
  logic [NG-1:0][GROUP-1:0] r1_a, r1_b;
  logic [NG-1:0]            r1_gp, r1_gg;
  logic [NG:0]              r1_c;

  // Capture operands and group lookahead results on accept.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r1_a  <= '0;
      r1_b  <= '0;
      r1_gp <= '0;
      r1_gg <= '0;
      r1_c  <= '0;
    end else if (w_adv1 && in_valid) begin
      r1_a  <= w_a;
      r1_b  <= w_beff;
      r1_gp <= w_gp;
      r1_gg <= w_gg;
      r1_c  <= w_c;
    end
  end

  // ---------------- stage 2 sum + flags ----------------
  logic [NG-1:0][GROUP-1:0] w_s;
  logic [WIDTH-1:0]         w_sum, w_a_flat, w_b_flat, w_s_fin;
  logic                     w_ovf, w_gw;

  for (genvar k = 0; k < NG; k++) begin : g_sum
    cla_grp_sum #(.GROUP(GROUP)) u_sum (
      .i_a (r1_a[k]),
      .i_b (r1_b[k]),
      .i_c (r1_c[k]),
      .o_s (w_s[k])
    );
  end

  assign w_sum    = w_s;
  assign w_a_flat = r1_a;
  assign w_b_flat = r1_b;
  // Carry into the MSB is recovered as sum ^ propagate at that bit.
  assign w_ovf    = r1_c[NG] ^ (w_sum[WIDTH-1] ^ w_a_flat[WIDTH-1] ^ w_b_flat[WIDTH-1]);

  // Word generate: group lookahead with a zero carry-in.
  always_comb begin
    w_gw = 1'b0;
    for (int k = 0; k < NG; k++) w_gw = r1_gg[k] | (r1_gp[k] & w_gw);
  end

`ifdef CLA_SAT_EN
  // Clamp toward the sign of A when the raw sum overflows.
  assign w_s_fin = !w_ovf ? w_sum :
                   w_a_flat[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_s_fin = w_sum;
`endif

  logic [WIDTH-1:0] r2_s;
  logic             r2_cout, r2_ovf, r2_pout, r2_gout;

  // Result registers advance only when the consumer side can move.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r2_s    <= '0;
      r2_cout <= 1'b0;
      r2_ovf  <= 1'b0;
      r2_pout <= 1'b0;
      r2_gout <= 1'b0;
    end else if (w_adv2 && r_vld_pipe[1]) begin
      r2_s    <= w_s_fin;
      r2_cout <= r1_c[NG];
      r2_ovf  <= w_ovf;
      r2_pout <= &r1_gp;
      r2_gout <= w_gw;
    end
  end

  assign S    = r2_s;
  assign Cout = r2_cout;
  assign Ovf  = r2_ovf;
  assign Pout = r2_pout;
  assign Gout = r2_gout;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (WIDTH=16, GROUP=4).
module tb_cla_addsub_pipe;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Sub = 1'b0, Cin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, Cout, Ovf, Pout, Gout, out_valid;
  logic [15:0] S;

  typedef struct packed {
    logic [15:0] s;
    logic        c, o, p, g;
  } exp_t;

  typedef struct packed {
    logic [15:0] a, b;
    logic        sub, cin;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, n_pop = 0;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .A(A), .B(B), .Sub(Sub), .Cin(Cin),
    .in_valid(in_valid), .in_ready(in_ready), .S(S), .Cout(Cout), .Ovf(Ovf),
    .Pout(Pout), .Gout(Gout), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  // Reference: plain wide arithmetic.
  function automatic exp_t model(input logic [15:0] a, b, input logic sub, cin);
    exp_t        r;
    logic [15:0] be;
    logic [16:0] t, t0;
    be  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, be} + {16'd0, cin ^ sub};
    t0  = {1'b0, a} + {1'b0, be};
    r.s = t[15:0];
    r.c = t[16];
    r.o = (a[15] == be[15]) && (t[15] != a[15]);
    r.p = &(a ^ be);
    r.g = t0[16];
`ifdef CLA_SAT_EN
    if (r.o) r.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got S=%h C=%b O=%b P=%b G=%b, required no output",
                   S, Cout, Ovf, Pout, Gout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          if ({S, Cout, Ovf, Pout, Gout} !== e) begin
            n_err++;
            $display("FAIL sb_result got S=%h C=%b O=%b P=%b G=%b, required S=%h C=%b O=%b P=%b G=%b",
                     S, Cout, Ovf, Pout, Gout, e.s, e.c, e.o, e.p, e.g);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(A, B, Sub, Cin));
    end
  end

  // Entered and left at posedge+1; returns once the op is accepted.
  task automatic send(input logic [15:0] a, b, input logic sub, cin);
    bit acc = 0;
    int t = 0;
    A = a; B = b; Sub = sub; Cin = cin; in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge Clk); #1;
      t++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    n_cmp++;
    if ({out_valid, S, Cout, Ovf, Pout, Gout} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs got ov=%b S=%h C=%b O=%b P=%b G=%b, required all 0",
               out_valid, S, Cout, Ovf, Pout, Gout);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %b, required 1", in_ready);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_directed();
    vec_t v[7];
    exp_t got;
    int   t;
`ifdef CLA_SAT_EN
    localparam logic [15:0] EXP4 = 16'h7FFF;
`else
    localparam logic [15:0] EXP4 = 16'h8000;
`endif
    v[0] = '{16'h1234, 16'h0FF0, 1'b0, 1'b0, '{16'h2224, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    v[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{EXP4,     1'b0, 1'b1, 1'b0, 1'b0}};
    v[5] = '{16'hAAAA, 16'h5555, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    v[6] = '{16'h8000, 16'h8000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(v[i].a, v[i].b, v[i].sub, v[i].cin);
      t = 0;
      do begin
        @(negedge Clk);
        t++;
      end while (!out_valid && t < 10);
      got = {S, Cout, Ovf, Pout, Gout};
      n_cmp++;
      if (!out_valid || got !== v[i].e) begin
        n_err++;
        $display("FAIL directed_%0d got ov=%b S=%h C=%b O=%b P=%b G=%b, required ov=1 S=%h C=%b O=%b P=%b G=%b",
                 i, out_valid, got.s, got.c, got.o, got.p, got.g,
                 v[i].e.s, v[i].e.c, v[i].e.o, v[i].e.p, v[i].e.g);
      end
      @(posedge Clk); #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [20:0] snap;
    int          pop0;
    pop0 = n_pop;
    out_ready = 1'b0;
    A = 16'h0101; B = 16'h0202; Sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_accept0 in_ready got %b, required 1", in_ready);
    end
    @(posedge Clk); #1;
    A = 16'h9000; B = 16'h9000; Sub = 1'b0; Cin = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_accept1 in_ready got %b, required 1", in_ready);
    end
    @(posedge Clk); #1;
    A = 16'h0010; B = 16'h0020; Sub = 1'b1; Cin = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    snap = {S, Cout, Ovf, Pout, Gout};
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {S, Cout, Ovf, Pout, Gout} !== snap) begin
        n_err++;
        $display("FAIL bp_hold_%0d got rdy=%b ov=%b out=%h, required 0/1 out=%h",
                 i, in_ready, out_valid, {S, Cout, Ovf, Pout, Gout}, snap);
      end
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    send(16'h0010, 16'h0020, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    wait_drain();
    n_cmp++;
    if (n_pop - pop0 != 4 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_count got %0d results (%0d pending), required 4 (0 pending)",
               n_pop - pop0, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    n_cmp++;
    if ({out_valid, S, Cout, Ovf, Pout, Gout} !== 21'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid got ov=%b S=%h C=%b O=%b P=%b G=%b rdy=%b, required zeros rdy=1",
               out_valid, S, Cout, Ovf, Pout, Gout, in_ready);
    end
    @(posedge Clk); #1;
    sb.delete();
    Reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_stale_%0d out_valid got %b, required 0", i, out_valid);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge Clk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge Clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rand_drain pending %0d, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
